fsm_led3_sequencer: RTL

Automatic stimulus controller for the 3-switch Moore LED FSM (`fsm_moore_led3`). The block replaces the physical `sw[2:0]` inputs with a programmable 8-entry step table. It plays the table out at a fixed dwell per step, once or looping, and supports start, stop and hold controls. In manual mode it passes the board switches through, registered, so the LED FSM can be driven either by hand or by a scripted sequence without rewiring.

---
 rtl/fsm_led3_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/fsm_led3_sequencer.sv
// fsm_led3_sequencer
// Scripted stimulus source for the 3-switch Moore LED FSM. Plays an 8-entry
// switch-code table at a fixed dwell per step, once or looping, or passes
// the board switches through when in manual mode.
//
// Control inputs are plain strobes/levels with no handshake: start, stop,
// wr_en and len_wr act on the rising edge where they are high, and the block
// never pushes back (there is no ready). hold, loop and mode are levels.
module fsm_led3_sequencer #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode,
    input  logic [2:0] sw_manual,
    input  logic       start,
    input  logic       stop,
    input  logic       hold,
    input  logic       loop,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [2:0] wr_data,
    input  logic       len_wr,
    input  logic [2:0] len_data,
    output logic [2:0] sw_out,
    output logic       busy,
    output logic [2:0] step_idx,
    output logic       done,
    output logic [1:0] state_dbg
);

    localparam int            CW   = 27;
    localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_nx;
    logic [CW-1:0]   cnt_q, cnt_nx;
    logic [2:0]      idx_q, idx_nx;
    logic [2:0]      sw_q, sw_nx;
    logic [2:0]      last_q;
    logic [2:0]      tbl [8];

    logic            go;
    logic            step_end;
    logic            last_step;
    logic [2:0]      idx_inc;

    // A start only counts when no stop arrives alongside it.
    assign go        = start && !stop;
    // Dwell expires on the terminal count unless hold stretches the step.
    assign step_end  = (state_q == S_RUN) && !hold && (cnt_q == TERM);
    // ">=" so a length shrunk below the current index ends the sequence.
    assign last_step = (idx_q >= last_q);
    assign idx_inc   = idx_q + 3'd1;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_nx;
    end

    // Next-state logic; manual mode overrides everything and parks in IDLE.
    always_comb begin
        state_nx = state_q;
        if (!mode) begin
            state_nx = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (go) state_nx = S_RUN;
                S_RUN: begin
                    if (stop)
                        state_nx = S_IDLE;
                    else if (step_end && last_step && !loop)
                        state_nx = S_DONE;
                end
                S_DONE:  state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Next values for the registered switch code, step index and dwell counter.
    always_comb begin
        sw_nx  = sw_q;
        idx_nx = idx_q;
        cnt_nx = cnt_q;
        if (!mode) begin
            sw_nx  = sw_manual;
            idx_nx = 3'd0;
            cnt_nx = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    idx_nx = 3'd0;
                    cnt_nx = '0;
                    sw_nx  = go ? tbl[0] : 3'b000;
                end
                S_RUN: begin
                    if (stop) begin
                        sw_nx  = 3'b000;
                        idx_nx = 3'd0;
                        cnt_nx = '0;
                    end else if (hold) begin
                        cnt_nx = cnt_q;
                    end else if (cnt_q == TERM) begin
                        cnt_nx = '0;
                        if (!last_step) begin
                            idx_nx = idx_inc;
                            sw_nx  = tbl[idx_inc];
                        end else if (loop) begin
                            idx_nx = 3'd0;
                            sw_nx  = tbl[0];
                        end else begin
                            idx_nx = 3'd0;
                            sw_nx  = 3'b000;
                        end
                    end else begin
                        cnt_nx = cnt_q + 1'b1;
                    end
                end
                default: begin
                    sw_nx  = 3'b000;
                    idx_nx = 3'd0;
                    cnt_nx = '0;
                end
            endcase
        end
    end

    // Datapath registers; sw_out only changes when a step is loaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_q  <= 3'b000;
            idx_q <= 3'd0;
            cnt_q <= '0;
        end else begin
            sw_q  <= sw_nx;
            idx_q <= idx_nx;
            cnt_q <= cnt_nx;
        end
    end

    // Step table and last index; reset restores the default script.
    always_ff @(posedge clk) begin
        if (reset) begin
            tbl[0] <= 3'b001;
            tbl[1] <= 3'b010;
            tbl[2] <= 3'b100;
            tbl[3] <= 3'b011;
            tbl[4] <= 3'b010;
            tbl[5] <= 3'b100;
            tbl[6] <= 3'b000;
            tbl[7] <= 3'b111;
            last_q <= 3'd7;
        end else begin
            if (wr_en)  tbl[wr_addr] <= wr_data;
            if (len_wr) last_q       <= len_data;
        end
    end

    // Outputs decode registered state only.
    always_comb begin
        sw_out    = sw_q;
        step_idx  = idx_q;
        busy      = (state_q == S_RUN);
        done      = (state_q == S_DONE);
        state_dbg = state_q;
    end

endmodule
